// File: rtl/POLI_types_pkg.sv
// ---------------------------------------------------------------------------
// POLI_types_pkg : shared POLI word size and APB master bridge state type
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package POLI_types_pkg;

  localparam int WORD_SIZE = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_master_state_t;

endpackage : POLI_types_pkg

`default_nettype wire

// File: rtl/apb_master_if.sv
// ---------------------------------------------------------------------------
// apb_master_if : APB signal bundle for back-to-back master/slave hookups
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface apb_master_if
  import POLI_types_pkg::*;
();

  logic                 PSEL;
  logic                 PENABLE;
  logic [WORD_SIZE-1:0] PADDR;
  logic                 PWRITE;
  logic [WORD_SIZE-1:0] PWDATA;
  logic                 PREADY;
  logic [WORD_SIZE-1:0] PRDATA;

  modport master (
    output PSEL, PENABLE, PADDR, PWRITE, PWDATA,
    input  PREADY, PRDATA
  );

  modport slave (
    input  PSEL, PENABLE, PADDR, PWRITE, PWDATA,
    output PREADY, PRDATA
  );

endinterface : apb_master_if

`default_nettype wire

// File: rtl/apb_master_bridge.sv
// ---------------------------------------------------------------------------
// apb_master_bridge : single-word request/response to APB initiator with timeout
// Revision          : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module apb_master_bridge
  import POLI_types_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8    // 2**CNT_W must exceed TIMEOUT_CYCLES
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [WORD_SIZE-1:0] req_addr,
  input  logic [WORD_SIZE-1:0] req_wdata,
  input  logic                 req_write,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WORD_SIZE-1:0] rsp_rdata,
  output logic                 rsp_timeout,
  output logic                 PSEL,
  output logic                 PENABLE,
  output logic [WORD_SIZE-1:0] PADDR,
  output logic                 PWRITE,
  output logic [WORD_SIZE-1:0] PWDATA,
  input  logic                 PREADY,
  input  logic [WORD_SIZE-1:0] PRDATA
);

  localparam bit               TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  apb_master_state_t    state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 psel_q, psel_d;
  logic                 penable_q, penable_d;
  logic [WORD_SIZE-1:0] paddr_q, paddr_d;
  logic                 pwrite_q, pwrite_d;
  logic [WORD_SIZE-1:0] pwdata_q, pwdata_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [WORD_SIZE-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_timeout_q, rsp_timeout_d;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          paddr_d   = req_addr;
          pwdata_d  = req_wdata;
          pwrite_d  = req_write;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        // PREADY is tested first so a completion on the last allowed cycle wins
        if (PREADY) begin
          rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          state_d       = RESP;
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          state_d       = RESP;
        end else if (TO_EN) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_timeout = rsp_timeout_q;
  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PADDR       = paddr_q;
  assign PWRITE      = pwrite_q;
  assign PWDATA      = pwdata_q;

endmodule : apb_master_bridge

`default_nettype wire

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- APB initiator that drives the APB bus, with PSEL/PENABLE/PADDR/PWRITE/PWDATA as outputs and PREADY/PRDATA as inputs.
- Accepts single-word read/write requests from an on-chip requester (e.g. the POLI test/DMA sequencer) over a valid/ready handshake.
- Runs one APB transfer per request and returns read data or write completion over a valid/ready response channel.
- Includes a wait-state timeout so a hung slave cannot deadlock the requester.

Parameters:
- WORD_SIZE, 32, data/address width; taken from POLI_types_pkg, not redefined locally.
- TIMEOUT_CYCLES, 255, maximum ACCESS cycles without PREADY before abort; 0 disables the timeout.
- CNT_W, 8, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- CLK  input  1  single clock for the whole block.
- RST  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_addr  input  WORD_SIZE  target address.
- req_wdata  input  WORD_SIZE  write data.
- req_write  input  1  1 = write, 0 = read.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester consumes the response.
- rsp_rdata  output  WORD_SIZE  read data; 0 for writes and timeouts.
- rsp_timeout  output  1  transfer aborted by timeout.
- PSEL  output  1  APB select.
- PENABLE  output  1  APB access phase.
- PADDR  output  WORD_SIZE  APB address.
- PWRITE  output  1  APB direction.
- PWDATA  output  WORD_SIZE  APB write data.
- PREADY  input  1  slave completes the transfer.
- PRDATA  input  WORD_SIZE  slave read data.

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-high.
- Reset values: all outputs 0 except req_ready, which is 1. State = IDLE, counter = 0.
- FSM states are IDLE, SETUP, ACCESS, RESP. All outputs are registered except req_ready, which equals (state==IDLE).
- IDLE:
  - On req_valid & req_ready, latch addr/wdata/write into PADDR/PWDATA/PWRITE.
  - Next state SETUP, with PSEL=1 and PENABLE=0.
- SETUP: always lasts exactly one cycle. Next state ACCESS, with PENABLE=1 and counter cleared.
- ACCESS:
  - PREADY=1: capture PRDATA into rsp_rdata when PWRITE=0 (rsp_rdata=0 for writes). Set rsp_timeout=0, drop PSEL/PENABLE, go to RESP with rsp_valid=1.
  - Else, if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: drop PSEL/PENABLE, set rsp_rdata=0 and rsp_timeout=1, go to RESP.
  - Else increment the counter and stay in ACCESS.
  - If PREADY and timeout occur in the same cycle, PREADY wins (normal completion).
- RESP: hold rsp_valid/rsp_rdata/rsp_timeout stable until rsp_ready=1. On that edge, clear rsp_valid and go to IDLE.
- Latency, with request accepted at edge 0:
  - PSEL high after edge 0.
  - PENABLE high after edge 1.
  - With zero wait states (PREADY=1 in the first ACCESS cycle), rsp_valid high after edge 2.
  - Each wait state adds one cycle. Back-to-back throughput is one transfer per 4 cycles minimum (IDLE cycle included).
- PADDR/PWRITE/PWDATA:
  - Stable from SETUP through ACCESS.
  - Retain their last values in IDLE/RESP and change only on request acceptance.
- PSEL/PENABLE are never high outside SETUP/ACCESS. PENABLE is never high without PSEL.
- Requests presented while req_ready=0 are ignored; the requester holds req_valid until accepted.
- Reset mid-transfer: on the RST edge, PSEL/PENABLE drop to 0, the transfer is abandoned, no response is produced, and the state returns to IDLE.
- The counter saturates at TIMEOUT_CYCLES-1 and never wraps. With TIMEOUT_CYCLES=0 the counter is unused and ACCESS waits indefinitely.

Decomposition:
- POLI_types_pkg: add the apb_master_state_t enum (IDLE, SETUP, ACCESS, RESP). Reuse the existing WORD_SIZE.
- An interface apb_master_if, carrying the APB signals with a master modport that mirrors the existing slave modport, lets benches connect master and slave back-to-back.
- No sub-module: FSM plus counter in a single module.

Test Plan:
- Zero-wait read:
  - Stimulus: req addr=0x0000_0004, write=0; slave PREADY=1, PRDATA=0xDEAD_BEEF.
  - Required: PSEL at cycle 1, PENABLE at cycle 2, rsp_valid at cycle 3 with rsp_rdata=0xDEAD_BEEF and rsp_timeout=0.
- Wait-state write:
  - Stimulus: addr=0x10, wdata=0x1234_5678, write=1; PREADY low for 3 ACCESS cycles.
  - Required: PADDR/PWDATA stable for all 5 APB cycles, rsp_valid at cycle 6, rsp_rdata=0.
- Timeout (TIMEOUT_CYCLES=4):
  - Stimulus: PREADY held 0.
  - Required: PSEL drops after the 4th ACCESS cycle, rsp_timeout=1, rsp_rdata=0. A second request then completes normally.
- Tie case (TIMEOUT_CYCLES=4):
  - Stimulus: PREADY=1 exactly in the 4th ACCESS cycle.
  - Required: rsp_timeout=0, PRDATA captured.
- Response backpressure:
  - Stimulus: rsp_ready=0 for 5 cycles while req_valid is held.
  - Required: rsp fields stable, req_ready=0 throughout. rsp_ready=1 gives IDLE next cycle; the second request is accepted the cycle after.
- Reset during ACCESS:
  - Stimulus: assert RST for 1 cycle during ACCESS.
  - Required: next cycle PSEL=PENABLE=0, rsp_valid=0, req_ready=1. No spurious response afterwards even if PREADY rises.
